// File: rtl/ctrl_signal_generator.sv
// Pixel-beat sequencer for the CNN datapath: walks col/row/channel counters and
// derives delayed conv/accumulator/max-pool strobes plus a sticky completion flag.
module ctrl_signal_generator #(
    parameter int unsigned IMG_W  = 10,
    parameter int unsigned IMG_H  = 5,
    parameter int unsigned K      = 3,
    parameter int unsigned NUM_CH = 100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic valid_in,
    output logic rst_n_conv,
    output logic valid_in_conv,
    output logic valid_in_accu,
    output logic valid_in_maxpool,
    output logic task_over
);

    localparam int unsigned COL_W = (IMG_W  > 1) ? $clog2(IMG_W)  : 1;
    localparam int unsigned ROW_W = (IMG_H  > 1) ? $clog2(IMG_H)  : 1;
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [CH_W-1:0]  ch_q, ch_d;

    logic beat, col_end, row_end, ch_end, win;

    // Pipeline stage registers (s1 = beat+1, s2 = beat+2)
    logic s1_win_q, s1_last_ch_q, s1_lom_q;
    logic s2_last_ch_q, s2_lom_q;
    logic conv_q, accu_q, maxpool_q, clr_n_q, task_over_q;

    always_comb begin
        beat    = valid_in && !task_over_q;
        col_end = (col_q == COL_W'(IMG_W - 1));
        row_end = (row_q == ROW_W'(IMG_H - 1));
        ch_end  = (ch_q == CH_W'(NUM_CH - 1));
        win     = (row_q >= ROW_W'(K - 1)) && (col_q >= COL_W'(K - 1));

        col_d = col_q;
        row_d = row_q;
        ch_d  = ch_q;
        if (beat) begin
            if (col_end) begin
                col_d = '0;
                if (row_end) begin
                    row_d = '0;
                    ch_d  = ch_end ? '0 : ch_q + 1'b1;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            col_q        <= '0;
            row_q        <= '0;
            ch_q         <= '0;
            s1_win_q     <= 1'b0;
            s1_last_ch_q <= 1'b0;
            s1_lom_q     <= 1'b0;
            s2_last_ch_q <= 1'b0;
            s2_lom_q     <= 1'b0;
            conv_q       <= 1'b0;
            accu_q       <= 1'b0;
            maxpool_q    <= 1'b0;
            clr_n_q      <= 1'b0;
            task_over_q  <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            ch_q         <= ch_d;
            s1_win_q     <= beat && win;
            s1_last_ch_q <= beat && win && ch_end;
            s1_lom_q     <= beat && col_end && row_end;
            s2_last_ch_q <= s1_last_ch_q;
            s2_lom_q     <= s1_lom_q;
            conv_q       <= beat;
            accu_q       <= s1_win_q;
            maxpool_q    <= s2_last_ch_q;
            // Clear pulse lands three cycles after the last pixel of each map
            clr_n_q      <= !s2_lom_q;
            task_over_q  <= task_over_q || (beat && col_end && row_end && ch_end);
        end
    end

    assign rst_n_conv       = clr_n_q;
    assign valid_in_conv    = conv_q;
    assign valid_in_accu    = accu_q;
    assign valid_in_maxpool = maxpool_q;
    assign task_over        = task_over_q;

endmodule

// File: tb/tb_ctrl_signal_generator.sv
// Directed bench for ctrl_signal_generator: pulse counts and strobe cycle positions
// checked against hand-computed values for the default 10x5x3, 100-channel config.
module tb_ctrl_signal_generator;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic valid_in = 1'b0;
    logic rst_n_conv, valid_in_conv, valid_in_accu, valid_in_maxpool, task_over;

    ctrl_signal_generator #(
        .IMG_W (10),
        .IMG_H (5),
        .K     (3),
        .NUM_CH(100)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid_in        (valid_in),
        .rst_n_conv      (rst_n_conv),
        .valid_in_conv   (valid_in_conv),
        .valid_in_accu   (valid_in_accu),
        .valid_in_maxpool(valid_in_maxpool),
        .task_over       (task_over)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int rel;
    int n_conv, n_accu, n_mp, n_clr;
    int first_conv, last_conv, first_accu, last_accu;
    int first_mp, last_mp, first_clr, last_clr;
    int conv_even, accu_odd, to_rise, to_low;

    function automatic int outs();
        return int'({rst_n_conv, valid_in_conv, valid_in_accu, valid_in_maxpool, task_over});
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        rel = 0;
        n_conv = 0; n_accu = 0; n_mp = 0; n_clr = 0;
        first_conv = -1; last_conv = -1; first_accu = -1; last_accu = -1;
        first_mp = -1; last_mp = -1; first_clr = -1; last_clr = -1;
        conv_even = 0; accu_odd = 0; to_rise = -1; to_low = 0;
    endtask

    task automatic sample();
        if (valid_in_conv) begin
            n_conv++;
            if (first_conv < 0) first_conv = rel;
            last_conv = rel;
            if (rel % 2 == 0) conv_even++;
        end
        if (valid_in_accu) begin
            n_accu++;
            if (first_accu < 0) first_accu = rel;
            last_accu = rel;
            if (rel % 2 == 1) accu_odd++;
        end
        if (valid_in_maxpool) begin
            n_mp++;
            if (first_mp < 0) first_mp = rel;
            last_mp = rel;
        end
        if (!rst_n_conv) begin
            n_clr++;
            if (first_clr < 0) first_clr = rel;
            last_clr = rel;
        end
        if (task_over && to_rise < 0) to_rise = rel;
        if (!task_over && to_rise >= 0) to_low++;
    endtask

    // Inputs change #1 after posedge; outputs are sampled on the negedge.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic drive(input int n, input bit gapped);
        for (int i = 0; i < n; i++) begin
            valid_in = gapped ? (i % 2 == 0) : 1'b1;
            tick();
        end
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        valid_in = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    // Leaves the bench one cycle past the first non-reset edge, ready for beat 0
    task automatic apply_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset hold with valid_in toggling
        rst_n = 1'b1;
        valid_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            valid_in = ~valid_in;
            @(negedge clk);
            check("reset_hold_outs", outs(), 0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_release_outs", outs(), 5'b10000);
        @(posedge clk);
        #1;

        // Single map, continuous
        clear_stats();
        drive(50, 1'b0);
        idle(10);
        check("single_conv_cnt", n_conv, 50);
        check("single_conv_first", first_conv, 1);
        check("single_conv_last", last_conv, 50);
        check("single_accu_cnt", n_accu, 24);
        check("single_accu_first", first_accu, 24);
        check("single_accu_last", last_accu, 51);
        check("single_clr_cnt", n_clr, 1);
        check("single_clr_cycle", first_clr, 52);
        check("single_mp_cnt", n_mp, 0);
        check("single_task_over", to_rise, -1);

        // Gapped single map: beats on even cycles 0..98
        apply_reset();
        clear_stats();
        drive(100, 1'b1);
        idle(10);
        check("gap_conv_cnt", n_conv, 50);
        check("gap_conv_even", conv_even, 0);
        check("gap_conv_last", last_conv, 99);
        check("gap_accu_cnt", n_accu, 24);
        check("gap_accu_odd", accu_odd, 0);
        check("gap_accu_first", first_accu, 46);
        check("gap_accu_last", last_accu, 100);
        check("gap_clr_cnt", n_clr, 1);
        check("gap_clr_cycle", first_clr, 101);
        check("gap_mp_cnt", n_mp, 0);

        // Full task
        apply_reset();
        clear_stats();
        drive(5000, 1'b0);
        idle(20);
        check("full_conv_cnt", n_conv, 5000);
        check("full_accu_cnt", n_accu, 2400);
        check("full_mp_cnt", n_mp, 24);
        check("full_mp_first", first_mp, 4975);
        check("full_mp_last", last_mp, 5002);
        check("full_clr_cnt", n_clr, 100);
        check("full_clr_first", first_clr, 52);
        check("full_clr_last", last_clr, 5002);
        check("full_to_rise", to_rise, 5000);
        check("full_to_low", to_low, 0);

        // Post-completion: further valid_in ignored, flag stays set
        clear_stats();
        drive(30, 1'b0);
        idle(5);
        check("post_conv_cnt", n_conv, 0);
        check("post_accu_cnt", n_accu, 0);
        check("post_mp_cnt", n_mp, 0);
        check("post_clr_cnt", n_clr, 0);
        check("post_to_rise", to_rise, 0);
        check("post_to_low", to_low, 0);

        // Reset mid-task after beat 1234, then a full restarted run
        apply_reset();
        clear_stats();
        drive(1234, 1'b0);
        rst_n = 1'b1;
        valid_in = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_outs_1", outs(), 0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_outs_2", outs(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_release_outs", outs(), 5'b10000);
        @(posedge clk);
        #1;
        clear_stats();
        drive(5000, 1'b0);
        idle(20);
        check("rerun_conv_cnt", n_conv, 5000);
        check("rerun_accu_cnt", n_accu, 2400);
        check("rerun_mp_cnt", n_mp, 24);
        check("rerun_clr_cnt", n_clr, 100);
        check("rerun_to_rise", to_rise, 5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
